// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : conv_pkg
//  Brief    : Shared types and helper functions for the convolution window
//             address generator (state encoding, counter sizing, kernel
//             slice lookup).
//  Revision : 1.0  initial release
// ============================================================================
package conv_pkg;

    // Scan controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of bits needed to encode 'value' distinct codes
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Width of a counter that must reach max_value; never narrower than 1 bit
    function automatic int cnt_width(input int max_value);
        int w;
        w = clog2(max_value + 1);
        return (w < 1) ? 1 : w;
    endfunction

    // LSB position of tap 'tap_idx' in the flat kernel; tap 0 sits in the MSBs
    function automatic int tap_lsb(input int tap_idx, input int k, input int wgt_w);
        return (k * k - 1 - tap_idx) * wgt_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_tap_counter.sv
`default_nettype none
// ============================================================================
//  Module   : conv_tap_counter
//  Brief    : Wrap counter for one scan dimension. Advances on inc, returns to
//             zero after reaching 'wrap' and raises carry on that step so the
//             next dimension can chain off it. The next value is exported so
//             the owner can register outputs derived from it in the same edge.
//  Revision : 1.0  initial release
// ============================================================================
module conv_tap_counter
    import conv_pkg::*;
#(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    input  logic [W-1:0] wrap,
    output logic [W-1:0] count_next,
    output logic         carry
);

    logic [W-1:0] count;
    logic         at_wrap;

    // Next-count and carry-out; clear has priority over inc
    always_comb begin
        at_wrap    = (count == wrap);
        carry      = inc && at_wrap;
        count_next = count;
        if (clear) begin
            count_next = '0;
        end else if (inc) begin
            count_next = at_wrap ? '0 : count + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv_window_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : conv_window_addr_gen
//  Brief    : Raster-scans a row-major image and emits K*K pixel RAM read
//             addresses per output window, one tap per cycle, each paired
//             with its kernel weight, under ready/valid flow control.
//             Optional macro CONV_PAD_EN: zero-padded "same" scan in which
//             out-of-image taps are flagged by tap_pad with the RAM read
//             suppressed.
//  Revision : 1.0  initial release
// ============================================================================
module conv_window_addr_gen
    import conv_pkg::*;
#(
    parameter int IMG_W  = 16,
    parameter int IMG_H  = 16,
    parameter int K      = 3,
    parameter int WGT_W  = 8,
    parameter int ADDR_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [K*K*WGT_W-1:0] kernel,
    input  logic                 tap_ready,
    output logic                 enable_ram,
    output logic [ADDR_W-1:0]    address_ram,
    output logic [WGT_W-1:0]     weight,
    output logic                 tap_valid,
    output logic                 tap_first,
    output logic                 tap_last,
    output logic                 tap_pad,
    output logic                 busy,
    output logic                 done
);

`ifdef CONV_PAD_EN
    // Window centres visit every pixel
    localparam int COL_MAX = IMG_W - 1;
    localparam int ROW_MAX = IMG_H - 1;
`else
    // Window origins stay fully inside the image
    localparam int COL_MAX = IMG_W - K;
    localparam int ROW_MAX = IMG_H - K;
`endif

    localparam int KW = cnt_width(K - 1);
    localparam int CW = cnt_width(COL_MAX);
    localparam int RW = cnt_width(ROW_MAX);

    localparam logic [KW-1:0] K_WRAP   = KW'(K - 1);
    localparam logic [CW-1:0] COL_WRAP = CW'(COL_MAX);
    localparam logic [RW-1:0] ROW_WRAP = RW'(ROW_MAX);

    state_t                 state;
    state_t                 state_next;
    logic [K*K*WGT_W-1:0]   kernel_q;
    logic [K*K*WGT_W-1:0]   kernel_src;
    logic                   accept;
    logic                   clear;
    logic                   load;
    logic                   present;

    logic [KW-1:0]          kx_next;
    logic [KW-1:0]          ky_next;
    logic [CW-1:0]          col_next;
    logic [RW-1:0]          row_next;
    logic                   kx_carry;
    logic                   ky_carry;
    logic                   col_carry;
    logic                   row_carry;

    logic [ADDR_W-1:0]      geo_addr;
    logic [WGT_W-1:0]       geo_wgt;
    logic                   geo_first;
    logic                   geo_last;
    logic                   geo_pad;

    logic                   valid_d;
    logic                   en_d;
    logic [ADDR_W-1:0]      addr_d;
    logic [WGT_W-1:0]       wgt_d;
    logic                   first_d;
    logic                   last_d;
    logic                   busy_d;
    logic                   done_d;

    assign accept = (state == RUN) && tap_valid && tap_ready;

    // The first tap is computed in the start cycle, before kernel_q is loaded
    assign kernel_src = (state == IDLE) ? kernel : kernel_q;

    // Scan position chain: kx -> ky -> out_col -> out_row
    conv_tap_counter #(.W(KW)) u_kx (
        .clk(clk), .reset(reset), .clear(clear), .inc(accept),
        .wrap(K_WRAP), .count_next(kx_next), .carry(kx_carry)
    );
    conv_tap_counter #(.W(KW)) u_ky (
        .clk(clk), .reset(reset), .clear(clear), .inc(kx_carry),
        .wrap(K_WRAP), .count_next(ky_next), .carry(ky_carry)
    );
    conv_tap_counter #(.W(CW)) u_col (
        .clk(clk), .reset(reset), .clear(clear), .inc(ky_carry),
        .wrap(COL_WRAP), .count_next(col_next), .carry(col_carry)
    );
    conv_tap_counter #(.W(RW)) u_row (
        .clk(clk), .reset(reset), .clear(clear), .inc(col_carry),
        .wrap(ROW_WRAP), .count_next(row_next), .carry(row_carry)
    );

    // Tap geometry for the position the counters move to on this edge
    always_comb begin
        int pos_y;
        int pos_x;
        int lin;
        int idx;
        pos_y = int'(row_next) + int'(ky_next);
        pos_x = int'(col_next) + int'(kx_next);
`ifdef CONV_PAD_EN
        pos_y   = pos_y - K / 2;
        pos_x   = pos_x - K / 2;
        geo_pad = (pos_y < 0) || (pos_y >= IMG_H) || (pos_x < 0) || (pos_x >= IMG_W);
`else
        geo_pad = 1'b0;
`endif
        lin       = geo_pad ? 0 : pos_y * IMG_W + pos_x;
        geo_addr  = lin[ADDR_W-1:0];
        idx       = int'(ky_next) * K + int'(kx_next);
        geo_wgt   = kernel_src[tap_lsb(idx, K, WGT_W) +: WGT_W];
        geo_first = (kx_next == '0) && (ky_next == '0);
        geo_last  = (kx_next == K_WRAP) && (ky_next == K_WRAP);
    end

    // Next state and next registered output values
    always_comb begin
        state_next = state;
        clear      = 1'b0;
        load       = 1'b0;
        present    = 1'b0;
        done_d     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clear      = 1'b1;
                    load       = 1'b1;
                    present    = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (accept && row_carry) begin
                    done_d     = 1'b1;
                    state_next = DONE;
                end else begin
                    present = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        valid_d = present;
        busy_d  = present;
        en_d    = present && !geo_pad;
        addr_d  = present ? geo_addr : '0;
        wgt_d   = present ? geo_wgt : '0;
        first_d = present && geo_first;
        last_d  = present && geo_last;
    end

    // State, latched kernel and registered tap outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            kernel_q    <= '0;
            tap_valid   <= 1'b0;
            enable_ram  <= 1'b0;
            address_ram <= '0;
            weight      <= '0;
            tap_first   <= 1'b0;
            tap_last    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_next;
            if (load) begin
                kernel_q <= kernel;
            end
            tap_valid   <= valid_d;
            enable_ram  <= en_d;
            address_ram <= addr_d;
            weight      <= wgt_d;
            tap_first   <= first_d;
            tap_last    <= last_d;
            busy        <= busy_d;
            done        <= done_d;
        end
    end

`ifdef CONV_PAD_EN
    // Pad flag travels with the other tap outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tap_pad <= 1'b0;
        end else begin
            tap_pad <= present && geo_pad;
        end
    end
`else
    assign tap_pad = 1'b0;
`endif

endmodule
`default_nettype wire
